// File: rtl/csr_timer_if.sv
// rtl/csr_timer_if.sv - software CSR access bus between the core and the timer block
interface csr_timer_if;
  logic        csr_software_query_en;
  logic [13:0] csr_addr;
  logic [31:0] csr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;

  modport master (
    output csr_software_query_en,
    output csr_addr,
    output csr_wen,
    output csr_wdata,
    input  csr_rdata,
    input  csr_hit
  );

  modport slave (
    input  csr_software_query_en,
    input  csr_addr,
    input  csr_wen,
    input  csr_wdata,
    output csr_rdata,
    output csr_hit
  );
endinterface

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - TID/TCFG/TVAL/TICLR timer CSRs, timer interrupt and 64-bit stable counter
module csr_timer #(
  parameter int          TIMER_N   = 32,
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic             clk,
  input  logic             rstn,
  csr_timer_if.slave       csr,
  output logic             timer_int,
  output logic [63:0]      stable_cnt
);

  localparam logic [13:0] ADDR_TID   = 14'h40;
  localparam logic [13:0] ADDR_TCFG  = 14'h41;
  localparam logic [13:0] ADDR_TVAL  = 14'h42;
  localparam logic [13:0] ADDR_TICLR = 14'h44;
  localparam int          IW         = TIMER_N - 2;

  logic [31:0]        tid_q;
  logic               tcfg_en_q;
  logic               tcfg_per_q;
  logic [IW-1:0]      tcfg_init_q;
  logic [TIMER_N-1:0] cnt_q;
  logic               int_q;
  logic [63:0]        stable_q;

  logic               sel_tid, sel_tcfg, sel_tval, sel_ticlr;
  logic               wr;
  logic [31:0]        tcfg_rd;
  logic [31:0]        tid_new;
  logic [TIMER_N-1:0] tcfg_new;
  logic [TIMER_N-1:0] reload_val;
  logic [TIMER_N-1:0] cnt_next;
  logic               int_set;
  logic               int_clr;

  assign sel_tid   = (csr.csr_addr == ADDR_TID);
  assign sel_tcfg  = (csr.csr_addr == ADDR_TCFG);
  assign sel_tval  = (csr.csr_addr == ADDR_TVAL);
  assign sel_ticlr = (csr.csr_addr == ADDR_TICLR);
  assign csr.csr_hit = sel_tid | sel_tcfg | sel_tval | sel_ticlr;
  assign wr = csr.csr_software_query_en & csr.csr_hit;

  assign tcfg_rd = 32'({tcfg_init_q, tcfg_per_q, tcfg_en_q});
  assign tid_new = (tid_q & ~csr.csr_wen) | (csr.csr_wdata & csr.csr_wen);
  // Only the implemented TCFG bits are merged; anything above TIMER_N-1 is dropped.
  assign tcfg_new = (tcfg_rd[TIMER_N-1:0] & ~csr.csr_wen[TIMER_N-1:0])
                  | (csr.csr_wdata[TIMER_N-1:0] & csr.csr_wen[TIMER_N-1:0]);
  assign reload_val = {tcfg_init_q, 2'b00};

  always_comb begin
    csr.csr_rdata = 32'h0;
    if (sel_tid)
      csr.csr_rdata = tid_q;
    else if (sel_tcfg)
      csr.csr_rdata = tcfg_rd;
    else if (sel_tval)
      csr.csr_rdata = 32'(cnt_q);
  end

  // A TCFG write reloads the counter and suppresses any expiry in the same cycle.
  always_comb begin
    cnt_next = cnt_q;
    int_set  = 1'b0;
    if (wr && sel_tcfg) begin
      cnt_next = {tcfg_new[TIMER_N-1:2], 2'b00};
    end else if (tcfg_en_q) begin
      if (cnt_q != '0) begin
        cnt_next = cnt_q - TIMER_N'(1);
        int_set  = (cnt_q == TIMER_N'(1));
      end else if (tcfg_per_q) begin
        cnt_next = reload_val;
      end
    end
  end

  assign int_clr = wr & sel_ticlr & csr.csr_wen[0] & csr.csr_wdata[0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tid_q       <= TID_RESET;
      tcfg_en_q   <= 1'b0;
      tcfg_per_q  <= 1'b0;
      tcfg_init_q <= '0;
      cnt_q       <= '0;
      int_q       <= 1'b0;
      stable_q    <= 64'h0;
    end else begin
      stable_q <= stable_q + 64'd1;
      if (wr && sel_tid)
        tid_q <= tid_new;
      if (wr && sel_tcfg) begin
        tcfg_en_q   <= tcfg_new[0];
        tcfg_per_q  <= tcfg_new[1];
        tcfg_init_q <= tcfg_new[TIMER_N-1:2];
      end
      cnt_q <= cnt_next;
      // Expiry wins over a simultaneous software clear.
      if (int_set)
        int_q <= 1'b1;
      else if (int_clr)
        int_q <= 1'b0;
    end
  end

  assign timer_int  = int_q;
  assign stable_cnt = stable_q;

endmodule

// File: tb/tb_csr_timer.sv
// tb/tb_csr_timer.sv - self-checking bench for csr_timer: vector table, directed sequences, random vs model
module tb_csr_timer;
  localparam int          TN     = 8;
  localparam logic [31:0] TIDR   = 32'hAAAA_5555;
  localparam logic [13:0] A_TID  = 14'h40;
  localparam logic [13:0] A_TCFG = 14'h41;
  localparam logic [13:0] A_TVAL = 14'h42;
  localparam logic [13:0] A_TICL = 14'h44;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        timer_int;
  logic [63:0] stable_cnt;

  csr_timer_if bus();

  csr_timer #(.TIMER_N(TN), .TID_RESET(TIDR)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .csr        (bus),
    .timer_int  (timer_int),
    .stable_cnt (stable_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] s_rdata;
  logic        s_hit;
  logic        s_int;
  logic [63:0] s_stable;

  logic [31:0]     m_tid;
  int unsigned     m_tcfg;
  int unsigned     m_cnt;
  bit              m_int;
  longint unsigned m_stable;

  typedef struct {
    bit          q;
    logic [13:0] a;
    logic [31:0] w;
    logic [31:0] d;
    logic [31:0] er;
    bit          eh;
  } vec_t;
  vec_t tbl[$];

  function automatic bit m_hit(input logic [13:0] a);
    return (a == A_TID) || (a == A_TCFG) || (a == A_TVAL) || (a == A_TICL);
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] a);
    if (a == A_TID)  return m_tid;
    if (a == A_TCFG) return m_tcfg;
    if (a == A_TVAL) return m_cnt;
    return 32'h0;
  endfunction

  task automatic m_step(input bit r, input bit q, input logic [13:0] a,
                        input logic [31:0] w, input logic [31:0] d);
    bit          wr;
    bit          set;
    int unsigned cfg_new;
    if (!r) begin
      m_tid = TIDR; m_tcfg = 0; m_cnt = 0; m_int = 0; m_stable = 0;
      return;
    end
    m_stable = m_stable + 1;
    wr  = q && m_hit(a);
    set = 0;
    if (wr && a == A_TCFG) begin
      cfg_new = ((m_tcfg & ~w) | (d & w)) % (1 << TN);
      m_tcfg  = cfg_new;
      m_cnt   = (cfg_new / 4) * 4;
    end else if (m_tcfg % 2 == 1) begin
      if (m_cnt > 0) begin
        if (m_cnt == 1) set = 1;
        m_cnt = m_cnt - 1;
      end else if ((m_tcfg / 2) % 2 == 1) begin
        m_cnt = (m_tcfg / 4) * 4;
      end
    end
    if (wr && a == A_TID) m_tid = (m_tid & ~w) | (d & w);
    if (set) m_int = 1;
    else if (wr && a == A_TICL && w[0] && d[0]) m_int = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive, sample before the rising edge, step the model, return at next falling edge.
  task automatic tick(input bit r, input bit q, input logic [13:0] a,
                      input logic [31:0] w, input logic [31:0] d);
    rstn = r;
    bus.csr_software_query_en = q;
    bus.csr_addr  = a;
    bus.csr_wen   = w;
    bus.csr_wdata = d;
    #1;
    s_rdata  = bus.csr_rdata;
    s_hit    = bus.csr_hit;
    s_int    = timer_int;
    s_stable = stable_cnt;
    @(posedge clk);
    m_step(r, q, a, w, d);
    @(negedge clk);
  endtask

  task automatic rd(input logic [13:0] a);
    tick(1'b1, 1'b0, a, 32'h0, 32'h0);
  endtask

  task automatic wrt(input logic [13:0] a, input logic [31:0] w, input logic [31:0] d);
    tick(1'b1, 1'b1, a, w, d);
  endtask

  int p_int[16] = '{0,0,0,0,1,1,0,0,0,1,1,1,1,1,1,1};

  initial begin
    bit          r, q;
    int          sel;
    logic [13:0] a;
    logic [31:0] w, d, er;
    bit          eh, ei;
    logic [63:0] es;

    tbl.push_back('{1'b0, A_TID,  32'h0,         32'h0,         32'hAAAA_5555, 1'b1});
    tbl.push_back('{1'b1, A_TID,  32'h0000_FFFF, 32'h1234_1234, 32'hAAAA_5555, 1'b1});
    tbl.push_back('{1'b0, A_TID,  32'h0,         32'h0,         32'hAAAA_1234, 1'b1});
    tbl.push_back('{1'b0, 14'h43, 32'h0,         32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b1, 14'h43, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0});
    tbl.push_back('{1'b0, A_TID,  32'hFFFF_FFFF, 32'h0,         32'hAAAA_1234, 1'b1});
    tbl.push_back('{1'b1, 14'h3FFF, 32'hFFFF_FFFF, 32'h0,       32'h0,         1'b0});
    tbl.push_back('{1'b0, A_TID,  32'h0,         32'h0,         32'hAAAA_1234, 1'b1});
    tbl.push_back('{1'b1, A_TCFG, 32'hFFFF_FFFF, 32'hFFFF_FF0A, 32'h0,         1'b1});
    tbl.push_back('{1'b0, A_TCFG, 32'h0,         32'h0,         32'h0000_000A, 1'b1});
    tbl.push_back('{1'b0, A_TVAL, 32'h0,         32'h0,         32'h8,         1'b1});
    tbl.push_back('{1'b1, A_TVAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8,         1'b1});
    tbl.push_back('{1'b0, A_TVAL, 32'h0,         32'h0,         32'h8,         1'b1});
    tbl.push_back('{1'b1, A_TICL, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1});
    tbl.push_back('{1'b1, A_TCFG, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_000A, 1'b1});
    tbl.push_back('{1'b0, A_TCFG, 32'h0,         32'h0,         32'h0000_000B, 1'b1});
    tbl.push_back('{1'b0, A_TVAL, 32'h0,         32'h0,         32'h7,         1'b1});

    tick(1'b0, 1'b0, 14'h0, 32'h0, 32'h0);
    tick(1'b0, 1'b0, 14'h0, 32'h0, 32'h0);
    rd(A_TID);
    check("reset_tid", s_rdata, TIDR);
    check("reset_int", s_int, 1'b0);
    check("reset_stable", s_stable, 64'h0);
    rd(A_TCFG);
    check("reset_tcfg", s_rdata, 32'h0);
    check("stable_step", s_stable, 64'h1);
    rd(A_TVAL);
    check("reset_tval", s_rdata, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(1'b1, tbl[i].q, tbl[i].a, tbl[i].w, tbl[i].d);
      check($sformatf("vec%0d_rdata", i), s_rdata, tbl[i].er);
      check($sformatf("vec%0d_hit", i), s_hit, tbl[i].eh);
      check($sformatf("vec%0d_int", i), s_int, 1'b0);
    end

    // One-shot expiry: InitVal=4 gives 16 decrements, interrupt on the 1->0 edge, then hold.
    tick(1'b0, 1'b0, 14'h0, 32'h0, 32'h0);
    wrt(A_TCFG, 32'hFFFF_FFFF, 32'h11);
    check("oneshot_old_tcfg", s_rdata, 32'h0);
    for (int e = 16; e >= 0; e--) begin
      rd(A_TVAL);
      check($sformatf("oneshot_tval%0d", e), s_rdata, e);
      check($sformatf("oneshot_int%0d", e), s_int, (e == 0));
    end
    for (int k = 0; k < 3; k++) begin
      rd(A_TVAL);
      check("oneshot_hold_tval", s_rdata, 32'h0);
      check("oneshot_hold_int", s_int, 1'b1);
    end

    // Clear with TVAL=5, then a clear that lands on expiry.
    wrt(A_TCFG, 32'hFFFF_FFFF, 32'h0D);
    check("reload_keeps_int", s_int, 1'b1);
    for (int e = 12; e >= 6; e--) begin
      rd(A_TVAL);
      check("clr_pre_tval", s_rdata, e);
    end
    wrt(A_TICL, 32'h1, 32'h1);
    check("ticlr_reads_zero", s_rdata, 32'h0);
    check("clr_int_before", s_int, 1'b1);
    rd(A_TVAL);
    check("clr_tval4", s_rdata, 32'h4);
    check("clr_int_after", s_int, 1'b0);

    // Periodic InitVal=1: 4,3,2,1,0 repeating; clears at idx 5, 8 and 13 (13 collides with expiry while set).
    wrt(A_TICL, 32'h1, 32'h1);
    wrt(A_TCFG, 32'hFFFF_FFFF, 32'h07);
    for (int i = 0; i < 16; i++) begin
      if (i == 5 || i == 8 || i == 13) begin
        wrt(A_TICL, 32'h1, 32'h1);
        check($sformatf("per_clr_rdata%0d", i), s_rdata, 32'h0);
      end else begin
        rd(A_TVAL);
        check($sformatf("per_tval%0d", i), s_rdata, 4 - (i % 5));
      end
      check($sformatf("per_int%0d", i), s_int, p_int[i]);
    end

    // TCFG write while TVAL=1 preempts the expiry; TVAL writes are ignored.
    wrt(A_TICL, 32'h1, 32'h1);
    rd(A_TVAL);
    check("pre_tval2", s_rdata, 32'h2);
    check("pre_int0", s_int, 1'b0);
    wrt(A_TCFG, 32'hFFFF_FFFF, 32'h09);
    check("tcfg_old_val", s_rdata, 32'h07);
    rd(A_TVAL);
    check("tcfg_reload_tval", s_rdata, 32'h8);
    check("tcfg_reload_noint", s_int, 1'b0);
    rd(A_TVAL);
    check("tval_7", s_rdata, 32'h7);
    wrt(A_TVAL, 32'hFFFF_FFFF, 32'h0);
    check("tval_wr_old", s_rdata, 32'h6);
    rd(A_TVAL);
    check("tval_wr_ignored", s_rdata, 32'h5);

    // Reset mid-count with a concurrent write.
    wrt(A_TID, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    tick(1'b0, 1'b1, A_TCFG, 32'hFFFF_FFFF, 32'h0F);
    rd(A_TID);
    check("rst_tid", s_rdata, TIDR);
    check("rst_int", s_int, 1'b0);
    check("rst_stable", s_stable, 64'h0);
    rd(A_TCFG);
    check("rst_tcfg", s_rdata, 32'h0);
    check("rst_stable1", s_stable, 64'h1);
    rd(A_TVAL);
    check("rst_tval", s_rdata, 32'h0);

    force dut.stable_q = 64'hFFFF_FFFF_FFFF_FFFE;
    release dut.stable_q;
    rd(A_TID);
    check("wrap_pre", s_stable, 64'hFFFF_FFFF_FFFF_FFFE);
    rd(A_TID);
    check("wrap_max", s_stable, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(A_TID);
    check("wrap_zero", s_stable, 64'h0);
    rd(A_TID);
    check("wrap_one", s_stable, 64'h1);

    // Randomised traffic against the model.
    tick(1'b0, 1'b0, 14'h0, 32'h0, 32'h0);
    for (int n = 0; n < 800; n++) begin
      r   = ($urandom_range(0, 63) != 0);
      q   = ($urandom_range(0, 4) != 0);
      sel = $urandom_range(0, 19);
      if (sel < 3)       a = A_TID;
      else if (sel < 5)  a = A_TCFG;
      else if (sel < 10) a = A_TVAL;
      else if (sel < 13) a = A_TICL;
      else if (sel < 15) a = 14'h43;
      else if (sel < 16) a = 14'($urandom);
      else               a = A_TVAL;
      w = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom;
      d = $urandom;
      if (a == A_TCFG) d[7:4] = 4'h0;
      er = m_read(a);
      eh = m_hit(a);
      ei = m_int;
      es = m_stable;
      tick(r, q, a, w, d);
      check($sformatf("rnd%0d_rdata", n), s_rdata, er);
      check($sformatf("rnd%0d_hit", n), s_hit, eh);
      check($sformatf("rnd%0d_int", n), s_int, ei);
      check($sformatf("rnd%0d_stable", n), s_stable, es);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_timer.md
CSR_TIMER -- requirements
Module: csr_timer

Interface
REQ-001 SHALL have parameter: TIMER_N, default 32, meaning timer width in bits (legal 3..32).
REQ-002 SHALL have parameter: TID_RESET, default 32'h0, meaning reset value of TID.
REQ-003 SHALL have port: clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port: rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: csr_software_query_en  input  1  software CSR access valid this cycle.
REQ-006 SHALL have port: csr_addr  input  14  CSR number.
REQ-007 SHALL have port: csr_wen  input  32  per-bit write enable.
REQ-008 SHALL have port: csr_wdata  input  32  write data.
REQ-009 SHALL have port: csr_rdata  output  32  read data; old (pre-write) value.
REQ-010 SHALL have port: csr_hit  output  1  csr_addr selects a CSR owned here.
REQ-011 SHALL have port: timer_int  output  1  timer interrupt pending (ESTAT.IS[11]).
REQ-012 SHALL have port: stable_cnt  output  64  stable counter for rdcnt.

Function
REQ-013 SHALL own CSRs: TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44; csr_hit=1 iff csr_addr is one of these, independent of query_en.
REQ-014 SHALL drive csr_rdata combinationally from current register state when csr_hit, else 0; read-first: a write in the same cycle is not visible until the next cycle.
REQ-015 SHALL perform writes at the rising edge where query_en=1 and csr_hit=1: new = (old & ~csr_wen) | (csr_wdata & csr_wen) on writable bits only.
REQ-016 SHALL implement TID as 32 writable bits.
REQ-017 SHALL implement TCFG: bit0 En, bit1 Periodic, bits[TIMER_N-1:2] InitVal, bits above TIMER_N-1 read 0 and ignore writes.
REQ-018 SHALL implement TVAL as read-only; bits[TIMER_N-1:0] = counter, upper bits read 0; writes ignored.
REQ-019 SHALL implement TICLR as reading 0; write with csr_wen[0]&csr_wdata[0] clears timer_int.
REQ-020 SHALL, on any TCFG write, load counter <= {new InitVal, 2'b00} at that edge.
REQ-021 SHALL, per cycle with En=1 and no TCFG write: counter!=0 -> counter-1; counter==1 -> also set timer_int.
REQ-022 SHALL, with En=1, counter==0, Periodic=1, no TCFG write: reload {InitVal,2'b00}, no interrupt; periodic interval = 4*InitVal+1 cycles.
REQ-023 SHALL, with En=1, counter==0, Periodic=0: hold counter at 0; no further interrupts.
REQ-024 SHALL, with En=0: hold counter; no interrupt generation.
REQ-025 SHALL give TCFG write priority over decrement/reload in the same cycle; no interrupt set that cycle.
REQ-026 SHALL give interrupt set priority over TICLR clear in the same cycle (timer_int stays 1).
REQ-027 SHALL increment stable_cnt by 1 every cycle, wrapping 2^64-1 -> 0; not software writable.
REQ-028 SHALL ignore writes when query_en=0 or csr_hit=0.

Reset
REQ-029 SHALL, when rstn=0 at a rising edge: TID<=TID_RESET, TCFG<=0, counter<=0, timer_int<=0, stable_cnt<=0; reset overrides any concurrent write or count.
REQ-030 SHALL resume counting from reset values on the first edge with rstn=1.

Verification
REQ-031 SHALL cover: write TCFG=0x0000_0011 (En=1, Periodic=0, InitVal=4) -> TVAL reads 0x10 next cycle, reaches 0 after 16 cycles, timer_int=1 same edge, TVAL then holds 0.
REQ-032 SHALL cover: TCFG=0x0000_0007 (InitVal=1, periodic) -> TVAL sequence 4,3,2,1,0,4,...; timer_int set on each 1->0.
REQ-033 SHALL cover: TICLR write wdata=1, wen=1 with TVAL=5 -> timer_int clears next cycle; same write coinciding with TVAL 1->0 -> timer_int stays 1.
REQ-034 SHALL cover: TID=0xAAAA_5555, write wen=0x0000_FFFF wdata=0x1234_1234 -> rdata in write cycle 0xAAAA_5555, next cycle 0xAAAA_1234.
REQ-035 SHALL cover: TCFG write while TVAL=1 -> TVAL loads new InitVal*4, no interrupt; TVAL write attempt -> unchanged.
REQ-036 SHALL cover: rstn=0 mid-count -> all registers reset; stable_cnt preloaded near 2^64-1 wraps to 0.
